// File: rtl/mio_bus_if.sv
// mio_bus_if: data-port bus between the single-cycle RISC-V core and its
// data-side bridge.
//   cpu_addr   byte address from the core (ALU result)
//   cpu_wdata  store data from the core
//   cpu_we     store strobe from the core (MemWrite)
//   cpu_rdata  combinational load data back to the core
// master = core side, slave = bridge side.
interface mio_bus_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [31:0] cpu_rdata;

  modport master (output cpu_addr, output cpu_wdata, output cpu_we, input cpu_rdata);
  modport slave  (input cpu_addr, input cpu_wdata, input cpu_we, output cpu_rdata);
endinterface

// File: rtl/mio_bus.sv
// mio_bus: data-side bridge behind the single-cycle RISC-V core.
// It decodes the core's data address and steers each access to one of three
// targets:
//   - the data RAM at 0x0000_0000, which is external and read combinationally
//   - the LED/switch GPIO register at 0xF000_0000
//   - a prescaled down-counter timer with TLOAD at 0xF000_0004 and TCTRL at
//     0xF000_0008
// Load data goes back in the same cycle. The level interrupt irq is
// pend & ie.
// An unmapped or misaligned access reads 0, and a write to it is ignored.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   cpu        mio_bus_if.slave (cpu_addr, cpu_wdata, cpu_we in; cpu_rdata out)
//   ram_addr   RAM word address = cpu_addr[RAM_AW+1:2]
//   ram_wdata  RAM write data = cpu_wdata
//   ram_we     RAM write enable (store that hits the RAM window)
//   ram_rdata  RAM combinational read data
//   sw_in      asynchronous board switches, 2-flop synchronized
//   led_out    LED register
//   irq        timer interrupt, level
//
// TCTRL layout: [0]=en, [1]=auto, [2]=ie (r/w); [31]=pend (read, write 1 clears).
// Writing en=1 starts a fresh load from IDLE or DONE. While the timer is
// already loading or running, writing en=1 only updates auto/ie and the
// countdown continues. Writing en=0 stops the timer from any state.
module mio_bus #(
  parameter int RAM_AW   = 10,
  parameter int PRESCALE = 16,
  parameter int LED_W    = 16,
  parameter int SW_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  mio_bus_if.slave          cpu,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out,
  output logic              irq
);

  localparam logic [31:0] RAM_LIMIT  = 32'd4 << RAM_AW;
  localparam logic [31:0] GPIO_ADDR  = 32'hF000_0000;
  localparam logic [31:0] TLOAD_ADDR = 32'hF000_0004;
  localparam logic [31:0] TCTRL_ADDR = 32'hF000_0008;

  localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [31:0]     count;
  logic [31:0]     reload;
  logic [PC_W-1:0] pc;
  logic            en, auto_en, ie, pend;
  logic [SW_W-1:0] sw_meta, sw_sync;

  // Address decode. The exact-match register addresses are implicitly aligned.
  logic aligned, hit_ram, hit_gpio, hit_tload, hit_tctrl;
  logic wr_gpio, wr_tload, wr_tctrl;

  assign aligned   = (cpu.cpu_addr[1:0] == 2'b00);
  assign hit_ram   = aligned && (cpu.cpu_addr < RAM_LIMIT);
  assign hit_gpio  = (cpu.cpu_addr == GPIO_ADDR);
  assign hit_tload = (cpu.cpu_addr == TLOAD_ADDR);
  assign hit_tctrl = (cpu.cpu_addr == TCTRL_ADDR);

  assign wr_gpio  = cpu.cpu_we && hit_gpio;
  assign wr_tload = cpu.cpu_we && hit_tload;
  assign wr_tctrl = cpu.cpu_we && hit_tctrl;

  assign ram_addr  = cpu.cpu_addr[RAM_AW+1:2];
  assign ram_wdata = cpu.cpu_wdata;
  assign ram_we    = cpu.cpu_we && hit_ram;

  // Load data mux, zero added latency.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    cpu.cpu_rdata = '0;
    if (hit_ram)
      cpu.cpu_rdata = ram_rdata;
    else if (hit_gpio)
      cpu.cpu_rdata = {16'(led_out), 16'(sw_sync)};
    else if (hit_tload)
      cpu.cpu_rdata = count;
    else if (hit_tctrl)
      cpu.cpu_rdata = {pend, 28'd0, ie, auto_en, en};
  end

  // Timer events. A count already at 0 (zero reload) expires on its first
  // tick without wrapping.
  logic tick, expire;
  assign tick   = (state == RUN) && (pc == PC_LAST);
  assign expire = tick && (count <= 32'd1);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (wr_tctrl && cpu.cpu_wdata[0]) state_next = LOAD;
      LOAD: state_next = RUN;
      RUN:  if (expire) state_next = auto_en ? LOAD : DONE;
      DONE: if (wr_tctrl && cpu.cpu_wdata[0]) state_next = LOAD;
      default: state_next = IDLE;
    endcase
    // Disabling wins over whatever the current state wanted to do.
    if (wr_tctrl && !cpu.cpu_wdata[0]) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_out <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
      reload  <= '0;
      count   <= '0;
      pc      <= '0;
      en      <= 1'b0;
      auto_en <= 1'b0;
      ie      <= 1'b0;
      pend    <= 1'b0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;

      if (wr_gpio)  led_out <= cpu.cpu_wdata[LED_W-1:0];
      if (wr_tload) reload  <= cpu.cpu_wdata;
      if (wr_tctrl) begin
        en      <= cpu.cpu_wdata[0];
        auto_en <= cpu.cpu_wdata[1];
        ie      <= cpu.cpu_wdata[2];
      end

      // Expiry has priority over a same-cycle write-1-to-clear.
      if (expire)
        pend <= 1'b1;
      else if (wr_tctrl && cpu.cpu_wdata[31])
        pend <= 1'b0;

      unique case (state)
        LOAD: begin
          count <= reload;
          pc    <= '0;
        end
        RUN: begin
          if (tick) begin
            pc <= '0;
            if (count != 32'd0) count <= count - 32'd1;
          end else begin
            pc <= pc + PC_W'(1);
          end
        end
        default: pc <= '0;
      endcase
    end
  end

  assign irq = pend && ie;

endmodule

// File: tb/tb_mio_bus.sv
// tb_mio_bus: directed test of the mio_bus data-side bridge.
// The test uses PRESCALE=2 so that timer expiries happen a few cycles
// apart. The bench models the data RAM as a simple array.
// Inputs change 1 ns after the rising edge. Outputs are sampled later in
// the same cycle, after they settle.
module tb_mio_bus;
  localparam int RAM_AW = 10;

  localparam logic [31:0] GPIO  = 32'hF000_0000;
  localparam logic [31:0] TLOAD = 32'hF000_0004;
  localparam logic [31:0] TCTRL = 32'hF000_0008;

  logic              clk;
  logic              rst;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic [31:0]       ram_rdata;
  logic [15:0]       sw_in;
  logic [15:0]       led_out;
  logic              irq;

  mio_bus_if bus ();

  mio_bus #(.RAM_AW(RAM_AW), .PRESCALE(2), .LED_W(16), .SW_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (bus),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .irq       (irq)
  );

  logic [31:0] mem [0:(1<<RAM_AW)-1];
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_we    = 1'b1;
    tick();
    bus.cpu_we    = 1'b0;
  endtask

  task automatic sel(input logic [31:0] a);
    bus.cpu_addr = a;
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1<<RAM_AW); i++) mem[i] = '0;
    rst = 1'b1;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.cpu_we = 1'b0;
    sw_in = '0;
    ticks(2);
    rst = 1'b0;

    // Reset state
    check("rst_led", 32'(led_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    sel(TCTRL); check("rst_tctrl", bus.cpu_rdata, 32'h0);
    sel(TLOAD); check("rst_tload", bus.cpu_rdata, 32'h0);

    // 1: RAM store then load
    bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEAD_BEEF; bus.cpu_we = 1'b1; #1;
    check("ram_we_store", 32'(ram_we), 32'h1);
    check("ram_addr", 32'(ram_addr), 32'h4);
    tick(); bus.cpu_we = 1'b0; #1;
    check("ram_we_load", 32'(ram_we), 32'h0);
    check("ram_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
    // RAM window boundaries
    bus.cpu_addr = 32'h0000_0FFC; bus.cpu_we = 1'b1; #1;
    check("ram_last_hit", 32'(ram_we), 32'h1);
    bus.cpu_addr = 32'h0000_1000; #1;
    check("ram_past_end", 32'(ram_we), 32'h0);
    bus.cpu_addr = 32'h0000_0012; #1;
    check("ram_misaligned_we", 32'(ram_we), 32'h0);
    check("ram_misaligned_rd", bus.cpu_rdata, 32'h0);
    bus.cpu_we = 1'b0;

    // 2: GPIO LED write, switch synchronizer
    sw_in = 16'h1234;
    store(GPIO, 32'h0000_A5A5);
    check("led_write", 32'(led_out), 32'hA5A5);
    sel(GPIO); check("gpio_sw_1edge", bus.cpu_rdata, 32'hA5A5_0000);
    tick(); check("gpio_sw_2edge", bus.cpu_rdata, 32'hA5A5_1234);

    // 5: unmapped and misaligned register accesses
    store(32'h8000_0000, 32'h1111_2222);
    sel(32'h8000_0000);
    check("unmapped_rd", bus.cpu_rdata, 32'h0);
    check("unmapped_led", 32'(led_out), 32'hA5A5);
    store(32'hF000_0002, 32'h0000_5A5A);
    sel(32'hF000_0002);
    check("misaligned_rd", bus.cpu_rdata, 32'h0);
    check("misaligned_led", 32'(led_out), 32'hA5A5);
    sel(32'h0); check("ram_word0_kept", bus.cpu_rdata, 32'h0);
    sel(32'h10); check("ram_word4_kept", bus.cpu_rdata, 32'hDEAD_BEEF);

    // 3: one-shot countdown, reload=3, en+ie
    store(TLOAD, 32'd3);
    sel(TLOAD); check("tload_no_count", bus.cpu_rdata, 32'h0);
    store(TCTRL, 32'h5);                  // E0: enter LOAD
    sel(TLOAD);
    tick(); check("oneshot_loaded", bus.cpu_rdata, 32'd3);   // E1
    ticks(5); check("oneshot_irq_early", 32'(irq), 32'h0);   // E6
    tick(); check("oneshot_irq", 32'(irq), 32'h1);           // E7
    check("oneshot_count0", bus.cpu_rdata, 32'h0);
    sel(TCTRL); check("oneshot_tctrl", bus.cpu_rdata, 32'h8000_0005);
    ticks(3);
    sel(TLOAD); check("done_holds0", bus.cpu_rdata, 32'h0);
    check("done_irq_held", 32'(irq), 32'h1);
    store(TCTRL, 32'h8000_0004);          // stop + clear pend
    sel(TCTRL); check("pend_cleared", bus.cpu_rdata, 32'h4);
    check("irq_cleared", 32'(irq), 32'h0);

    // 4: auto reload, reload=2
    store(TLOAD, 32'd2);
    store(TCTRL, 32'h7);                  // A0
    ticks(5);                             // A5: first expiry
    sel(TCTRL); check("auto_pend1", bus.cpu_rdata, 32'h8000_0007);
    tick();                               // A6: reloaded
    sel(TLOAD); check("auto_reload", bus.cpu_rdata, 32'd2);
    store(TCTRL, 32'h8000_0007);          // A7: clear pend, keep running
    sel(TCTRL); check("auto_clr", bus.cpu_rdata, 32'h7);
    ticks(2);                             // A9
    sel(TLOAD); check("auto_count1", bus.cpu_rdata, 32'd1);
    store(TCTRL, 32'h8000_0000);          // A10: clear during expiry
    sel(TCTRL); check("expiry_beats_clear", bus.cpu_rdata, 32'h8000_0000);
    tick();
    sel(TLOAD); check("stopped_count", bus.cpu_rdata, 32'h0);

    // 6: reset while running with count=5
    store(TLOAD, 32'd5);
    store(TCTRL, 32'h5);                  // B0: LOAD (pend still set)
    tick();                               // B1: RUN, count=5
    sel(TLOAD); check("pre_rst_count", bus.cpu_rdata, 32'd5);
    check("pre_rst_irq", 32'(irq), 32'h1);
    bus.cpu_addr = GPIO; bus.cpu_wdata = 32'h0000_FFFF; bus.cpu_we = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.cpu_we = 1'b0;
    check("rst_abort_led", 32'(led_out), 32'h0);
    check("rst_irq_mid", 32'(irq), 32'h0);
    sel(GPIO); check("rst_sw_sync", bus.cpu_rdata, 32'h0);
    sel(TCTRL); check("rst_tctrl_mid", bus.cpu_rdata, 32'h0);
    sel(TLOAD); check("rst_count_mid", bus.cpu_rdata, 32'h0);
    ticks(3);
    check("rst_idle_holds", bus.cpu_rdata, 32'h0);
    sel(GPIO); check("sw_resync", bus.cpu_rdata, 32'h0000_1234);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
